// File: rtl/redun_mont_pkg.sv
// Shared types for the redundant-form Montgomery squaring wrapper and its
// sequencer: operand layout and the loop-controller state encoding.
package redun_mont_pkg;

  localparam int WRD_W    = 16;
  localparam int NUM_WRDS = 8;

  // Redundant operand: NUM_WRDS little-endian words, word 0 is least significant.
  typedef logic [NUM_WRDS-1:0][WRD_W-1:0] redun0_t;

  typedef enum logic [2:0] {
    SQL_IDLE     = 3'd0,
    SQL_WAIT_RDY = 3'd1,
    SQL_RST      = 3'd2,
    SQL_ISSUE    = 3'd3,
    SQL_WAIT_RES = 3'd4,
    SQL_DONE     = 3'd5,
    SQL_ERR      = 3'd6
  } sq_loop_state_e;

endpackage

// File: rtl/redun_sq_loop_ctrl.sv
// Iterated-squaring sequencer: resets the squaring core, then feeds each
// result back as the next operand until the requested count is reached.
module redun_sq_loop_ctrl
  import redun_mont_pkg::*;
#(
  parameter int ITER_W  = 64,
  parameter int RST_CYC = 8,
  parameter int TMO_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_job_start,
  input  logic [ITER_W-1:0] i_job_iters,
  input  redun0_t           i_job_init,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output redun0_t           o_result,
  output logic [ITER_W-1:0] o_iter_cnt,
  output logic              o_err_tmo,
  output logic              o_err_spur,
  output logic              o_reset_mont,
  output logic              o_sq_start,
  output redun0_t           o_sq_in,
  input  redun0_t           i_sq_out,
  input  logic              i_sq_valid,
  input  logic              i_sq_ready
);

  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  sq_loop_state_e    state_q, state_d;
  redun0_t           cur;
  redun0_t           result_q;
  logic [ITER_W-1:0] iters_q;
  logic [ITER_W-1:0] iter_cnt;
  logic [RC_W-1:0]   rst_cnt;
  logic [TMO_W-1:0]  wd;
  logic              done_q;
  logic              err_tmo_q;
  logic              err_spur_q;
  logic              flush_q;

  logic accept;
  logic take_res;
  logic last_res;
  logic tmo_hit;
  logic in_idle;

  always_comb begin
    in_idle  = (state_q == SQL_IDLE);
    accept   = in_idle && i_job_start;
    take_res = (state_q == SQL_WAIT_RES) && i_sq_valid && !i_abort;
    last_res = ((iter_cnt + ITER_W'(1)) == iters_q);
    tmo_hit  = 1'b0;
    if (!i_abort) begin
      if (state_q == SQL_ISSUE && !i_sq_ready)
        tmo_hit = 1'b1;
      // A dropped ready while waiting is handled the same as a lost result.
      if (state_q == SQL_WAIT_RES && !i_sq_valid && (!i_sq_ready || wd == '1))
        tmo_hit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SQL_IDLE: begin
        if (i_job_start)
          state_d = (i_job_iters == '0) ? SQL_DONE : SQL_WAIT_RDY;
      end
      SQL_WAIT_RDY: begin
        if (i_sq_ready)
          state_d = SQL_RST;
      end
      SQL_RST: begin
        if (rst_cnt == '0)
          state_d = SQL_ISSUE;
      end
      SQL_ISSUE: begin
        state_d = i_sq_ready ? SQL_WAIT_RES : SQL_ERR;
      end
      SQL_WAIT_RES: begin
        if (i_sq_valid)
          state_d = last_res ? SQL_DONE : SQL_ISSUE;
        else if (tmo_hit)
          state_d = SQL_ERR;
      end
      SQL_DONE: state_d = SQL_IDLE;
      SQL_ERR:  state_d = SQL_IDLE;
      default:  state_d = SQL_IDLE;
    endcase
    if (i_abort && !in_idle)
      state_d = SQL_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= SQL_IDLE;
      cur        <= '0;
      result_q   <= '0;
      iter_cnt   <= '0;
      rst_cnt    <= '0;
      wd         <= '0;
      done_q     <= 1'b0;
      err_tmo_q  <= 1'b0;
      err_spur_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == SQL_DONE) && !i_abort;
      // Leaving through ERR or abort pulses the core reset to discard in-flight results.
      flush_q <= !in_idle && (i_abort || state_q == SQL_ERR);

      if (accept) begin
        cur        <= i_job_init;
        iter_cnt   <= '0;
        err_tmo_q  <= 1'b0;
        err_spur_q <= 1'b0;
      end

      if (state_q == SQL_WAIT_RDY)
        rst_cnt <= RC_W'(RST_CYC - 1);
      else if (state_q == SQL_RST && rst_cnt != '0)
        rst_cnt <= rst_cnt - RC_W'(1);

      if (state_q == SQL_ISSUE)
        wd <= '0;
      else if (state_q == SQL_WAIT_RES)
        wd <= wd + TMO_W'(1);

      if (take_res) begin
        cur      <= i_sq_out;
        iter_cnt <= iter_cnt + ITER_W'(1);
      end

      if (tmo_hit)
        err_tmo_q <= 1'b1;

      if (i_sq_valid && state_q != SQL_WAIT_RES)
        err_spur_q <= 1'b1;

      if (state_q == SQL_DONE && !i_abort)
        result_q <= cur;
    end
  end

  // Iteration target is pure data and only meaningful after an accepted job.
  always_ff @(posedge i_clk) begin
    if (accept)
      iters_q <= i_job_iters;
  end

  assign o_busy       = !in_idle;
  assign o_done       = done_q;
  assign o_result     = result_q;
  assign o_iter_cnt   = iter_cnt;
  assign o_err_tmo    = err_tmo_q;
  assign o_err_spur   = err_spur_q;
  assign o_reset_mont = (state_q == SQL_RST) || flush_q;
  assign o_sq_start   = (state_q == SQL_ISSUE);
  assign o_sq_in      = cur;

endmodule

// File: tb/tb_redun_sq_loop_ctrl.sv
// Directed bench for redun_sq_loop_ctrl with a behavioural squaring-core model
// (square mod 251 on word 0, 10-cycle latency, optional dropped result).
module tb_redun_sq_loop_ctrl;
  import redun_mont_pkg::*;

  localparam int ITER_W  = 64;
  localparam int RST_CYC = 8;
  localparam int TMO_W   = 6;
  localparam int MOD_N   = 251;

  logic              clk = 1'b0;
  logic              rst;
  logic              job_start;
  logic [ITER_W-1:0] job_iters;
  redun0_t           job_init;
  logic              abort;
  logic              busy, done, err_tmo, err_spur, reset_mont, sq_start;
  redun0_t           result, sq_in, sq_out;
  logic [ITER_W-1:0] iter_cnt;
  logic              sq_valid, sq_ready;

  logic    m_valid = 1'b0;
  redun0_t m_data = '0;
  logic    m_busy = 1'b0;
  int      m_lat = 0;
  int      m_idx = 0;
  logic [WRD_W-1:0] m_in = '0;
  int      drop_idx;
  logic    stray_valid;
  redun0_t stray_data;

  int n_start = 0, n_rst = 0, n_done = 0;
  int b_st, b_rs, b_dn;
  int n_chk = 0, n_err = 0;

  assign sq_valid = m_valid | stray_valid;
  assign sq_out   = stray_valid ? stray_data : m_data;

  always #5 clk = ~clk;

  redun_sq_loop_ctrl #(.ITER_W(ITER_W), .RST_CYC(RST_CYC), .TMO_W(TMO_W)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_job_start(job_start), .i_job_iters(job_iters), .i_job_init(job_init),
    .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_result(result), .o_iter_cnt(iter_cnt),
    .o_err_tmo(err_tmo), .o_err_spur(err_spur),
    .o_reset_mont(reset_mont), .o_sq_start(sq_start), .o_sq_in(sq_in),
    .i_sq_out(sq_out), .i_sq_valid(sq_valid), .i_sq_ready(sq_ready)
  );

  // Squaring core model; its reset input discards any pending result.
  always @(negedge clk) begin
    m_valid = 1'b0;
    if (rst || reset_mont) begin
      m_busy = 1'b0;
      m_idx  = 0;
    end else begin
      if (m_busy) begin
        m_lat = m_lat - 1;
        if (m_lat == 0) begin
          m_busy = 1'b0;
          m_idx  = m_idx + 1;
          if (m_idx != drop_idx) begin
            m_data    = '0;
            m_data[0] = WRD_W'((32'(m_in) * 32'(m_in)) % MOD_N);
            m_valid   = 1'b1;
          end
        end
      end
      if (sq_start) begin
        m_busy = 1'b1;
        m_lat  = 10;
        m_in   = sq_in[0];
      end
    end
  end

  always @(negedge clk) begin
    if (sq_start)   n_start++;
    if (reset_mont) n_rst++;
    if (done)       n_done++;
  end

  task automatic snap();
    @(negedge clk);
    #1;
    b_st = n_start; b_rs = n_rst; b_dn = n_done;
  endtask

  task automatic launch(input logic [ITER_W-1:0] t, input logic [WRD_W-1:0] v);
    job_iters = t;
    job_init = '0;
    job_init[0] = v;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, done, err_tmo, err_spur, reset_mont, sq_start} !== 6'b0 || result !== '0 ||
        iter_cnt !== '0 || sq_in !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b done=%b tmo=%b spur=%b rmont=%b start=%b cnt=%0d required all 0",
               busy, done, err_tmo, err_spur, reset_mont, sq_start, iter_cnt);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || reset_mont !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b rmont=%b required 0 0", busy, reset_mont);
    end
  endtask

  task automatic test_t3();
    snap();
    launch(3, 16'd2);
    n_chk++;
    if (busy !== 1'b1 || reset_mont !== 1'b0) begin
      n_err++;
      $display("FAIL t3_cycle1: busy=%b rmont=%b required 1 0", busy, reset_mont);
    end
    repeat (RST_CYC) @(negedge clk);
    n_chk++;
    if (reset_mont !== 1'b1 || sq_start !== 1'b0) begin
      n_err++;
      $display("FAIL t3_last_rst: rmont=%b start=%b required 1 0", reset_mont, sq_start);
    end
    @(negedge clk);
    n_chk++;
    if (sq_start !== 1'b1 || reset_mont !== 1'b0 || sq_in[0] !== 16'd2) begin
      n_err++;
      $display("FAIL t3_first_issue: start=%b rmont=%b in=%0d required 1 0 2", sq_start, reset_mont, sq_in[0]);
    end
    for (int i = 0; i < 500 && done !== 1'b1; i++) @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || result[0] !== 16'd5 || iter_cnt !== 64'd3 || err_tmo !== 1'b0) begin
      n_err++;
      $display("FAIL t3_result: done=%b result=%0d cnt=%0d tmo=%b required 1 5 3 0", done, result[0], iter_cnt, err_tmo);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL t3_after: done=%b busy=%b required 0 0", done, busy);
    end
    n_chk++;
    if (n_start - b_st != 3 || n_rst - b_rs != RST_CYC || n_done - b_dn != 1) begin
      n_err++;
      $display("FAIL t3_counts: starts=%0d rmont=%0d dones=%0d required 3 %0d 1",
               n_start - b_st, n_rst - b_rs, n_done - b_dn, RST_CYC);
    end
  endtask

  task automatic test_t0();
    snap();
    launch(0, 16'h5);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL t0_cycle1: done=%b busy=%b required 0 1", done, busy);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || result[0] !== 16'h5 || iter_cnt !== '0) begin
      n_err++;
      $display("FAIL t0_done: done=%b result=%0h cnt=%0d required 1 5 0", done, result[0], iter_cnt);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (n_start != b_st || n_rst != b_rs) begin
      n_err++;
      $display("FAIL t0_no_core: starts=%0d rmont=%0d required 0 0", n_start - b_st, n_rst - b_rs);
    end
  endtask

  task automatic test_ready_low();
    int bad = 0;
    sq_ready = 1'b0;
    snap();
    launch(1, 16'd3);
    for (int i = 0; i < 50; i++) begin
      if (reset_mont !== 1'b0 || busy !== 1'b1 || sq_start !== 1'b0) bad++;
      @(negedge clk);
    end
    n_chk++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL rdy_hold: bad_cycles=%0d required 0", bad);
    end
    sq_ready = 1'b1;
    for (int i = 0; i < 500 && done !== 1'b1; i++) @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || result[0] !== 16'd9 || iter_cnt !== 64'd1) begin
      n_err++;
      $display("FAIL rdy_result: done=%b result=%0d cnt=%0d required 1 9 1", done, result[0], iter_cnt);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (n_rst - b_rs != RST_CYC) begin
      n_err++;
      $display("FAIL rdy_rst_len: rmont=%0d required %0d", n_rst - b_rs, RST_CYC);
    end
  endtask

  task automatic test_timeout();
    drop_idx = 2;
    snap();
    launch(3, 16'd2);
    for (int i = 0; i < 1000 && busy === 1'b1; i++) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || err_tmo !== 1'b1 || iter_cnt !== 64'd1 || reset_mont !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_err: busy=%b tmo=%b cnt=%0d rmont=%b required 0 1 1 1", busy, err_tmo, iter_cnt, reset_mont);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (reset_mont !== 1'b0 || n_done != b_dn || n_rst - b_rs != RST_CYC + 1) begin
      n_err++;
      $display("FAIL tmo_flush: rmont=%b dones=%0d rmont_cycles=%0d required 0 0 %0d",
               reset_mont, n_done - b_dn, n_rst - b_rs, RST_CYC + 1);
    end
    drop_idx = 0;
  endtask

  task automatic test_spurious();
    @(negedge clk);
    stray_data = '0;
    stray_data[0] = 16'd77;
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    n_chk++;
    if (err_spur !== 1'b1 || result[0] !== 16'd9 || busy !== 1'b0 || err_tmo !== 1'b1) begin
      n_err++;
      $display("FAIL spur_idle: spur=%b result=%0d busy=%b tmo=%b required 1 9 0 1", err_spur, result[0], busy, err_tmo);
    end
  endtask

  task automatic test_abort();
    snap();
    launch(10, 16'd2);
    n_chk++;
    if (err_tmo !== 1'b0 || err_spur !== 1'b0) begin
      n_err++;
      $display("FAIL abort_clear: tmo=%b spur=%b required 0 0", err_tmo, err_spur);
    end
    for (int i = 0; i < 500 && iter_cnt !== 64'd2; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || reset_mont !== 1'b1 || iter_cnt !== 64'd2) begin
      n_err++;
      $display("FAIL abort_idle: busy=%b rmont=%b cnt=%0d required 0 1 2", busy, reset_mont, iter_cnt);
    end
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    n_chk++;
    if (n_done != b_dn || err_spur !== 1'b1 || iter_cnt !== 64'd2) begin
      n_err++;
      $display("FAIL abort_quiet: dones=%0d spur=%b cnt=%0d required 0 1 2", n_done - b_dn, err_spur, iter_cnt);
    end
    @(negedge clk);
    launch(1, 16'd3);
    n_chk++;
    if (err_tmo !== 1'b0 || err_spur !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_next_clear: tmo=%b spur=%b busy=%b required 0 0 1", err_tmo, err_spur, busy);
    end
    for (int i = 0; i < 500 && done !== 1'b1; i++) @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || iter_cnt !== 64'd1 || result[0] !== 16'd9) begin
      n_err++;
      $display("FAIL abort_next_job: done=%b cnt=%0d result=%0d required 1 1 9", done, iter_cnt, result[0]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    launch(3, 16'd2);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({busy, done, err_tmo, err_spur, reset_mont, sq_start} !== 6'b0 || result !== '0 || iter_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b rmont=%b start=%b result=%0d cnt=%0d required all 0",
               busy, done, reset_mont, sq_start, result[0], iter_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || reset_mont !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_release: busy=%b rmont=%b required 0 0", busy, reset_mont);
    end
  endtask

  initial begin
    rst = 1'b1;
    job_start = 1'b0;
    job_iters = '0;
    job_init = '0;
    abort = 1'b0;
    sq_ready = 1'b1;
    drop_idx = 0;
    stray_valid = 1'b0;
    stray_data = '0;
    test_reset();
    test_t3();
    test_t0();
    test_ready_low();
    test_timeout();
    test_spurious();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
